// File: rtl/ariane_pkg.sv
// Shared types for the commit-side fence/maintenance sequencer.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ariane_pkg;

    // Operations the commit stage can hand to the fence sequencer.
    typedef enum logic [1:0] {
        FENCE_OP_FENCE        = 2'd0,
        FENCE_OP_FENCE_I      = 2'd1,
        FENCE_OP_SFENCE_VMA   = 2'd2,
        FENCE_OP_FLUSH_DCACHE = 2'd3
    } fence_op_t;

    // Operations that write back / invalidate the data cache before completing.
    function automatic logic fence_op_needs_dcache(input fence_op_t op);
        return (op == FENCE_OP_FENCE) || (op == FENCE_OP_FENCE_I) ||
               (op == FENCE_OP_FLUSH_DCACHE);
    endfunction

    // Operations that invalidate the instruction cache on completion.
    function automatic logic fence_op_flushes_icache(input fence_op_t op);
        return (op == FENCE_OP_FENCE_I) || (op == FENCE_OP_FLUSH_DCACHE);
    endfunction

endpackage

// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA / D$ flush: drain stores, optional D$ flush, then flush pulses.
// Latency: done 2 cycles after accept plus store-drain wait plus D$ flush cycles (bounded by FLUSH_TIMEOUT).
// Backpressure: one op in flight; req_ready_o is low while busy or halted, requester holds its request.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   halt_i                        debug halt, gates acceptance only
//   req_valid_i/req_op_i/req_ready_o  op handshake from commit
//   no_st_pending_i               store buffer empty
//   dcache_flush_o/dcache_flush_ack_i  level request / single-cycle ack to D$
//   icache_flush_o, tlb_flush_o, flush_pipeline_o, done_o, timeout_o  single-cycle completion pulses
//   busy_o                        op in flight
module fence_sequencer
    import ariane_pkg::*;
#(
    parameter bit          DCACHE_FLUSH_EN = 1'b1,
    parameter int unsigned FLUSH_TIMEOUT   = 1024
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      halt_i,
    input  logic      req_valid_i,
    input  fence_op_t req_op_i,
    output logic      req_ready_o,
    input  logic      no_st_pending_i,
    output logic      dcache_flush_o,
    input  logic      dcache_flush_ack_i,
    output logic      icache_flush_o,
    output logic      tlb_flush_o,
    output logic      flush_pipeline_o,
    output logic      done_o,
    output logic      timeout_o,
    output logic      busy_o
);

    localparam int unsigned CNT_W = (FLUSH_TIMEOUT == 0) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam int unsigned LIMIT_INT = (FLUSH_TIMEOUT == 0) ? 0 : (FLUSH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT_INT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DC_REQ,
        ST_FINISH
    } state_t;

    state_t           state_q, state_d;
    fence_op_t        op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= FENCE_OP_FENCE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        cnt_d            = cnt_q;
        tmo_d            = tmo_q;
        req_ready_o      = 1'b0;
        dcache_flush_o   = 1'b0;
        icache_flush_o   = 1'b0;
        tlb_flush_o      = 1'b0;
        flush_pipeline_o = 1'b0;
        done_o           = 1'b0;
        timeout_o        = 1'b0;
        busy_o           = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = !halt_i;
                if (req_valid_i && !halt_i) begin
                    op_d    = req_op_i;
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (no_st_pending_i) begin
                    if (DCACHE_FLUSH_EN && fence_op_needs_dcache(op_q)) begin
                        state_d = ST_DC_REQ;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_DC_REQ: begin
                dcache_flush_o = 1'b1;
                // An ack landing on the limit cycle wins: the flush did complete.
                if (dcache_flush_ack_i) begin
                    cnt_d   = '0;
                    state_d = ST_FINISH;
                end else if ((FLUSH_TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_FINISH;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_FINISH: begin
                done_o           = 1'b1;
                flush_pipeline_o = 1'b1;
                icache_flush_o   = fence_op_flushes_icache(op_q);
                tlb_flush_o      = (op_q == FENCE_OP_SFENCE_VMA);
                timeout_o        = tmo_q;
                tmo_d            = 1'b0;
                state_d          = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fence_sequencer.sv
// Testbench for fence_sequencer: two instances (D$ flush enabled with an 8-cycle timeout, and disabled).
// Latency: n/a.
// Backpressure: n/a.
module tb_fence_sequencer;
    import ariane_pkg::*;

    localparam int T = 8;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      halt;
    logic      valid_a, valid_b;
    fence_op_t op;
    logic      no_st;
    logic      ack;

    logic ready_a, dc_a, ic_a, tlb_a, pipe_a, done_a, tmo_a, busy_a;
    logic ready_b, dc_b, ic_b, tlb_b, pipe_b, done_b, tmo_b, busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fence_sequencer #(.DCACHE_FLUSH_EN(1'b1), .FLUSH_TIMEOUT(T)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt),
        .req_valid_i(valid_a), .req_op_i(op), .req_ready_o(ready_a),
        .no_st_pending_i(no_st), .dcache_flush_o(dc_a), .dcache_flush_ack_i(ack),
        .icache_flush_o(ic_a), .tlb_flush_o(tlb_a), .flush_pipeline_o(pipe_a),
        .done_o(done_a), .timeout_o(tmo_a), .busy_o(busy_a)
    );

    fence_sequencer #(.DCACHE_FLUSH_EN(1'b0), .FLUSH_TIMEOUT(T)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt),
        .req_valid_i(valid_b), .req_op_i(op), .req_ready_o(ready_b),
        .no_st_pending_i(no_st), .dcache_flush_o(dc_b), .dcache_flush_ack_i(ack),
        .icache_flush_o(ic_b), .tlb_flush_o(tlb_b), .flush_pipeline_o(pipe_b),
        .done_o(done_b), .timeout_o(tmo_b), .busy_o(busy_b)
    );

    // Output vector order: {ready, busy, dcache, icache, tlb, pipeline, done, timeout}
    function automatic logic [7:0] obs(input int sel);
        if (sel == 0) return {ready_a, busy_a, dc_a, ic_a, tlb_a, pipe_a, done_a, tmo_a};
        return {ready_b, busy_b, dc_b, ic_b, tlb_b, pipe_b, done_b, tmo_b};
    endfunction

    // One operation from acceptance to completion, checked cycle by cycle against
    // a timeline computed from the op, drain delay d and ack delay a.
    // Entered and left at 1 time unit after a rising edge.
    task automatic run_op(input int sel, input fence_op_t o, input int d, input int a,
                          input bit rnd, input bit tail, input string name);
        bit   need, acked, tmo;
        int   n, fin, last;
        logic [7:0] exp, got;
        need  = (sel == 0) && (o != FENCE_OP_SFENCE_VMA);
        acked = need && (a < T);
        tmo   = need && !acked;
        n     = !need ? 0 : (acked ? a + 1 : T);
        fin   = 2 + d + n;
        last  = tail ? fin + 1 : fin;
        for (int c = 0; c <= last; c++) begin
            halt = (rnd && c >= 1 && c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == 0) begin
                op = o;
                if (sel == 0) valid_a = 1'b1; else valid_b = 1'b1;
            end else begin
                op = fence_op_t'($urandom_range(0, 3));
                if (sel == 0) valid_a = (rnd && c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
                else          valid_b = (rnd && c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (c >= 1 && c <= d)   no_st = 1'b0;
            else if (c == 1 + d)    no_st = 1'b1;
            else                    no_st = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (need && c >= 2 + d && c < 2 + d + n) ack = acked && (c == 2 + d + a);
            else                                     ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;

            exp[7] = (c == 0) || (c > fin);
            exp[6] = (c >= 1) && (c <= fin);
            exp[5] = need && (c >= 2 + d) && (c < 2 + d + n);
            exp[4] = (c == fin) && ((o == FENCE_OP_FENCE_I) || (o == FENCE_OP_FLUSH_DCACHE));
            exp[3] = (c == fin) && (o == FENCE_OP_SFENCE_VMA);
            exp[2] = (c == fin);
            exp[1] = (c == fin);
            exp[0] = (c == fin) && tmo;

            @(negedge clk);
            got = obs(sel);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s op=%0d d=%0d a=%0d cycle %0d: got %b want %b",
                         name, o, d, a, c, got, exp);
            end
            @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        ack     = 1'b0;
        halt    = 1'b0;
        no_st   = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; halt = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        op = FENCE_OP_FENCE; no_st = 1'b1; ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs(0) !== 8'h80 || obs(1) !== 8'h80) begin
            bad++;
            $display("FAIL reset_outputs: got %b/%b want 10000000", obs(0), obs(1));
        end
        halt = 1'b1;
        #1;
        total++;
        if (obs(0) !== 8'h00) begin
            bad++;
            $display("FAIL reset_halt_ready: got %b want 00000000", obs(0));
        end
        @(posedge clk);
        #1;
        halt  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_op(0, FENCE_OP_SFENCE_VMA,   0, 0,   0, 1, "sfence_vma");
        run_op(0, FENCE_OP_FENCE,        0, 0,   0, 1, "fence_ack_first");
        run_op(0, FENCE_OP_FENCE_I,      5, 3,   0, 1, "fence_i_drain_ack");
        run_op(0, FENCE_OP_FENCE,        0, 100, 0, 1, "fence_timeout");
        run_op(0, FENCE_OP_FLUSH_DCACHE, 1, T-1, 0, 1, "ack_at_limit");
        run_op(0, FENCE_OP_FLUSH_DCACHE, 2, T,   0, 1, "ack_after_limit");
    endtask

    task automatic test_no_dcache;
        run_op(1, FENCE_OP_FENCE,        0, 0, 0, 1, "nodc_fence");
        run_op(1, FENCE_OP_FENCE_I,      3, 0, 0, 1, "nodc_fence_i");
        run_op(1, FENCE_OP_FLUSH_DCACHE, 0, 0, 1, 1, "nodc_flush_dc");
    endtask

    task automatic test_halt;
        logic [7:0] got;
        halt    = 1'b1;
        valid_a = 1'b1;
        op      = FENCE_OP_SFENCE_VMA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = obs(0);
            total++;
            if (got !== 8'h00) begin
                bad++;
                $display("FAIL halt_idle cycle %0d: got %b want 00000000", c, got);
            end
            @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
        halt    = 1'b0;
        run_op(0, FENCE_OP_FENCE, 3, 1, 1, 1, "halt_mid_op");
    endtask

    task automatic test_async_reset;
        valid_a = 1'b1;
        op      = FENCE_OP_FENCE;
        no_st   = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (dc_a !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_dc_req: got %b want 1", dc_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs(0) !== 8'h80) begin
            bad++;
            $display("FAIL async_reset_outputs: got %b want 10000000", obs(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (obs(0) !== 8'h80) begin
                bad++;
                $display("FAIL post_reset_idle cycle %0d: got %b want 10000000", c, obs(0));
            end
            @(posedge clk); #1;
        end
        // A fresh timeout must take the full window again after reset.
        run_op(0, FENCE_OP_FENCE, 0, 100, 0, 1, "post_reset_timeout");
    endtask

    task automatic test_back_to_back;
        run_op(0, FENCE_OP_SFENCE_VMA, 0, 0, 0, 0, "b2b_1");
        run_op(0, FENCE_OP_SFENCE_VMA, 0, 0, 0, 0, "b2b_2");
        run_op(0, FENCE_OP_FENCE_I,    0, 0, 0, 0, "b2b_3");
        run_op(0, FENCE_OP_FENCE,      1, 2, 0, 1, "b2b_4");
    endtask

    task automatic test_random;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_op(sel, fence_op_t'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 10)), 1, (i == 39) ? 1'b1 : 1'($urandom_range(0, 1)),
                   "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_no_dcache();
        test_halt();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
